mem_stage: RTL and testbench

Memory-access stage of the rv32i five-stage pipeline, directly downstream of the execute (ALU) stage and upstream of writeback. It registers the ALU result and either passes it through or performs a single load/store on a Wishbone-style data bus. Loads get byte-lane extraction and sign/zero extension; stores get lane steering. While a bus transaction is outstanding, the block stalls execute.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared rv32i definitions used by the memory stage: one-hot opcode bit
// positions, funct3 access-size codes and the alignment rule.
package mem_stage_pkg;

  localparam int RV_OPCODE_WIDTH = 11;

  localparam int OPC_RTYPE  = 0;
  localparam int OPC_ITYPE  = 1;
  localparam int OPC_LOAD   = 2;
  localparam int OPC_STORE  = 3;
  localparam int OPC_BRANCH = 4;
  localparam int OPC_JAL    = 5;
  localparam int OPC_JALR   = 6;
  localparam int OPC_LUI    = 7;
  localparam int OPC_AUIPC  = 8;
  localparam int OPC_SYSTEM = 9;
  localparam int OPC_FENCE  = 10;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  // Halfwords must sit on even addresses and words on multiples of four.
  function automatic logic misaligned_access(input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
    case (funct3)
      FUNCT3_H, FUNCT3_HU: return addr_lo[0];
      FUNCT3_W:            return addr_lo != 2'b00;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero
// extension for loads. Purely combinational so the D-cache can reuse it.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  sel,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Select byte enables, replicate store data, and align/extend load data.
  always_comb begin
    sel         = 4'b0000;
    store_lanes = 32'h0;
    load_data   = 32'h0;
    shifted     = load_word >> {byte_off, 3'b000};
    case (funct3)
      FUNCT3_B, FUNCT3_BU: begin
        sel         = 4'b0001 << byte_off;
        store_lanes = {4{store_data[7:0]}};
        load_data   = (funct3 == FUNCT3_BU) ? {24'h0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
      end
      FUNCT3_H, FUNCT3_HU: begin
        sel         = byte_off[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{store_data[15:0]}};
        load_data   = (funct3 == FUNCT3_HU) ? {16'h0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        sel         = 4'b1111;
        store_lanes = store_data;
        load_data   = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rv32i memory stage: registers ALU results, or runs one Wishbone
// load/store per instruction while stalling execute.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int OPCODE_WIDTH = RV_OPCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_ce,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_rd,
  input  logic [31:0]             i_rs2,
  input  logic [4:0]              i_rd_addr,
  input  logic                    i_wr_reg_valid,
  input  logic                    i_stall,
  input  logic                    i_flush,
  output logic                    o_stall,
  output logic                    o_ce,
  output logic [OPCODE_WIDTH-1:0] o_opcode,
  output logic [31:0]             o_rd,
  output logic [4:0]              o_rd_addr,
  output logic                    o_wr_reg_valid,
  output logic                    o_misaligned,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [31:0]             o_wb_addr,
  output logic [31:0]             o_wb_data,
  output logic [3:0]              o_wb_sel,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_stall,
  input  logic [31:0]             i_wb_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic        is_load, is_store, is_mem;
  logic        accept, misaligned, bus_done;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        load_q;
  logic [2:0]  align_funct3;
  logic [1:0]  align_off;
  logic [3:0]  lane_sel;
  logic [31:0] lane_store, lane_load;

  assign is_load    = i_opcode[OPC_LOAD];
  assign is_store   = i_opcode[OPC_STORE];
  assign is_mem     = is_load || is_store;
  assign o_stall    = (state != IDLE) || (i_stall && o_ce);
  assign accept     = (state == IDLE) && i_ce && !o_stall && !i_flush;
  assign misaligned = misaligned_access(i_funct3, i_rd[1:0]);
  assign bus_done   = ((state == REQ) && !i_wb_stall && i_wb_ack) ||
                      ((state == WAIT) && i_wb_ack);

  // The aligner sees the incoming access in IDLE (store steering) and the
  // latched access afterwards (load extraction).
  assign align_funct3 = (state == IDLE) ? i_funct3 : funct3_q;
  assign align_off    = (state == IDLE) ? i_rd[1:0] : addr_lo_q;

  mem_lane_align u_align (
    .funct3      (align_funct3),
    .byte_off    (align_off),
    .store_data  (i_rs2),
    .load_word   (i_wb_data),
    .sel         (lane_sel),
    .store_lanes (lane_store),
    .load_data   (lane_load)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: aligned memory ops walk REQ/WAIT/DONE, everything else stays in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mem && !misaligned) state_next = REQ;
      REQ:  if (!i_wb_stall) state_next = i_wb_ack ? DONE : WAIT;
      WAIT: if (i_wb_ack) state_next = DONE;
      DONE: if (!i_stall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and bus registers; everything holds while writeback stalls a valid result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_ce           <= 1'b0;
      o_opcode       <= '0;
      o_rd           <= 32'h0;
      o_rd_addr      <= 5'h0;
      o_wr_reg_valid <= 1'b0;
      o_misaligned   <= 1'b0;
      o_wb_cyc       <= 1'b0;
      o_wb_stb       <= 1'b0;
      o_wb_we        <= 1'b0;
      o_wb_addr      <= 32'h0;
      o_wb_data      <= 32'h0;
      o_wb_sel       <= 4'h0;
      funct3_q       <= 3'h0;
      addr_lo_q      <= 2'h0;
      load_q         <= 1'b0;
    end else begin
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (!o_stall) begin
            o_ce           <= 1'b0;
            o_wr_reg_valid <= 1'b0;
            if (accept) begin
              o_opcode  <= i_opcode;
              o_rd_addr <= i_rd_addr;
              o_rd      <= i_rd;
              if (is_mem && misaligned) begin
                o_ce         <= 1'b1;
                o_misaligned <= 1'b1;
              end else if (is_mem) begin
                o_wb_cyc       <= 1'b1;
                o_wb_stb       <= 1'b1;
                o_wb_we        <= is_store;
                o_wb_addr      <= {i_rd[31:2], 2'b00};
                o_wb_data      <= lane_store;
                o_wb_sel       <= lane_sel;
                funct3_q       <= i_funct3;
                addr_lo_q      <= i_rd[1:0];
                load_q         <= is_load;
                o_wr_reg_valid <= is_load && i_wr_reg_valid;
              end else begin
                o_ce           <= 1'b1;
                o_wr_reg_valid <= i_wr_reg_valid;
              end
            end
          end
        end
        REQ, WAIT: begin
          if ((state == REQ) && !i_wb_stall) o_wb_stb <= 1'b0;
          if (bus_done) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_ce     <= 1'b1;
            if (load_q) o_rd <= lane_load;
          end
        end
        DONE: begin
          if (!i_stall) begin
            o_ce           <= 1'b0;
            o_wr_reg_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// loads/stores/ALU ops checked against a byte-arithmetic reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int OW = RV_OPCODE_WIDTH;

  logic          clk, reset;
  logic          i_ce, i_wr_reg_valid, i_stall, i_flush;
  logic [OW-1:0] i_opcode;
  logic [2:0]    i_funct3;
  logic [31:0]   i_rd, i_rs2;
  logic [4:0]    i_rd_addr;
  logic          o_stall, o_ce, o_wr_reg_valid, o_misaligned;
  logic [OW-1:0] o_opcode;
  logic [31:0]   o_rd;
  logic [4:0]    o_rd_addr;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0]   o_wb_addr, o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_ack, i_wb_stall;
  logic [31:0]   i_wb_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [OW-1:0] op_alu, op_load, op_store;

  mem_stage dut (
    .clk(clk), .reset(reset), .i_ce(i_ce), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_rd(i_rd), .i_rs2(i_rs2), .i_rd_addr(i_rd_addr), .i_wr_reg_valid(i_wr_reg_valid),
    .i_stall(i_stall), .i_flush(i_flush), .o_stall(o_stall), .o_ce(o_ce),
    .o_opcode(o_opcode), .o_rd(o_rd), .o_rd_addr(o_rd_addr),
    .o_wr_reg_valid(o_wr_reg_valid), .o_misaligned(o_misaligned),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: access size in bytes decides alignment.
  function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    size = 1 << f3[1:0];
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * addr[1:0]);
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b100: v = v & 32'hFF;
      3'b101: v = v & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_sel(input logic [2:0] f3, input logic [31:0] addr);
    case (f3[1:0])
      2'b00:   return 4'b0001 << addr[1:0];
      2'b01:   return 4'b0011 << addr[1:0];
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3[1:0])
      2'b00:   return rs2[7:0] * 32'h0101_0101;
      2'b01:   return rs2[15:0] * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  task automatic run_alu(input logic [31:0] rd, input logic [4:0] rd_addr,
                         input logic wr, input string name);
    @(negedge clk);
    i_ce = 1'b1; i_opcode = op_alu; i_rd = rd; i_rd_addr = rd_addr;
    i_wr_reg_valid = wr; i_funct3 = 3'($urandom);
    @(negedge clk);
    i_ce = 1'b0;
    tests_run++; if (o_ce !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s o_ce got %b want 1", name, o_ce); end
    tests_run++; if (o_rd !== rd) begin tests_failed++; $display("[TB] FAIL %s o_rd got %h want %h", name, o_rd, rd); end
    tests_run++; if (o_rd_addr !== rd_addr) begin tests_failed++; $display("[TB] FAIL %s o_rd_addr got %0d want %0d", name, o_rd_addr, rd_addr); end
    tests_run++; if (o_wr_reg_valid !== wr) begin tests_failed++; $display("[TB] FAIL %s o_wr_reg_valid got %b want %b", name, o_wr_reg_valid, wr); end
    tests_run++; if (o_opcode !== op_alu) begin tests_failed++; $display("[TB] FAIL %s o_opcode got %h want %h", name, o_opcode, op_alu); end
    tests_run++; if (o_wb_cyc !== 1'b0 || o_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s cyc/stall got %b/%b want 0/0", name, o_wb_cyc, o_stall); end
  endtask

  task automatic run_mem(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rdata, input logic [4:0] rd_addr,
                         input int bus_stall, input int ack_wait, input string name);
    logic mis;
    logic [31:0] exp_rd, exp_data, exp_addr;
    logic [3:0] exp_sel;
    mis = model_misaligned(f3, addr);
    exp_rd = model_load(f3, addr, rdata);
    exp_sel = model_sel(f3, addr);
    exp_data = model_store(f3, rs2);
    exp_addr = addr & 32'hFFFF_FFFC;
    @(negedge clk);
    i_ce = 1'b1; i_opcode = store ? op_store : op_load; i_funct3 = f3; i_rd = addr;
    i_rs2 = rs2; i_rd_addr = rd_addr; i_wr_reg_valid = !store; i_wb_data = rdata;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0;
    @(negedge clk);
    i_ce = 1'b0;
    if (mis) begin
      tests_run++; if (o_misaligned !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s o_misaligned got %b want 1", name, o_misaligned); end
      tests_run++; if (o_wb_cyc !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s misaligned cyc got %b want 0", name, o_wb_cyc); end
      tests_run++; if (o_ce !== 1'b1 || o_wr_reg_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s misaligned ce/wr got %b/%b want 1/0", name, o_ce, o_wr_reg_valid); end
      @(negedge clk);
      tests_run++; if (o_misaligned !== 1'b0 || o_wb_cyc !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s misaligned pulse/cyc after got %b/%b want 0/0", name, o_misaligned, o_wb_cyc); end
      return;
    end
    tests_run++; if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s req cyc/stb got %b/%b want 1/1", name, o_wb_cyc, o_wb_stb); end
    tests_run++; if (o_wb_we !== store) begin tests_failed++; $display("[TB] FAIL %s we got %b want %b", name, o_wb_we, store); end
    tests_run++; if (o_wb_addr !== exp_addr) begin tests_failed++; $display("[TB] FAIL %s addr got %h want %h", name, o_wb_addr, exp_addr); end
    tests_run++; if (o_wb_sel !== exp_sel) begin tests_failed++; $display("[TB] FAIL %s sel got %b want %b", name, o_wb_sel, exp_sel); end
    if (store) begin
      tests_run++; if (o_wb_data !== exp_data) begin tests_failed++; $display("[TB] FAIL %s wb_data got %h want %h", name, o_wb_data, exp_data); end
    end
    tests_run++; if (o_stall !== 1'b1 || o_ce !== 1'b0 || o_misaligned !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s req stall/ce/mis got %b/%b/%b want 1/0/0", name, o_stall, o_ce, o_misaligned); end
    for (int k = 0; k < bus_stall; k++) begin
      i_wb_stall = 1'b1;
      @(negedge clk);
      tests_run++;
      if (o_wb_stb !== 1'b1 || o_wb_addr !== exp_addr || o_wb_sel !== exp_sel ||
          (store && o_wb_data !== exp_data)) begin
        tests_failed++;
        $display("[TB] FAIL %s bus-stall hold stb=%b addr=%h sel=%b data=%h want 1/%h/%b/%h",
                 name, o_wb_stb, o_wb_addr, o_wb_sel, o_wb_data, exp_addr, exp_sel, exp_data);
      end
    end
    i_wb_stall = 1'b0;
    if (ack_wait == 0) begin
      i_wb_ack = 1'b1;
      @(negedge clk);
      i_wb_ack = 1'b0;
    end else begin
      @(negedge clk);
      tests_run++; if (o_wb_stb !== 1'b0 || o_wb_cyc !== 1'b1 || o_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s wait stb/cyc/stall got %b/%b/%b want 0/1/1", name, o_wb_stb, o_wb_cyc, o_stall); end
      for (int k = 1; k < ack_wait; k++) @(negedge clk);
      i_wb_ack = 1'b1;
      @(negedge clk);
      i_wb_ack = 1'b0;
    end
    tests_run++; if (o_ce !== 1'b1 || o_wb_cyc !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s done ce/cyc got %b/%b want 1/0", name, o_ce, o_wb_cyc); end
    tests_run++; if (o_wr_reg_valid !== !store || o_rd_addr !== rd_addr) begin tests_failed++; $display("[TB] FAIL %s done wr/rd_addr got %b/%0d want %b/%0d", name, o_wr_reg_valid, o_rd_addr, !store, rd_addr); end
    if (!store) begin
      tests_run++; if (o_rd !== exp_rd) begin tests_failed++; $display("[TB] FAIL %s load data got %h want %h", name, o_rd, exp_rd); end
    end
    tests_run++; if (o_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s done stall got %b want 1", name, o_stall); end
    @(negedge clk);
    tests_run++; if (o_ce !== 1'b0 || o_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s after done ce/stall got %b/%b want 0/0", name, o_ce, o_stall); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (o_ce !== 0 || o_wr_reg_valid !== 0 || o_misaligned !== 0 || o_wb_cyc !== 0 ||
        o_wb_stb !== 0 || o_wb_we !== 0 || o_wb_sel !== 0 || o_stall !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset controls ce=%b wr=%b mis=%b cyc=%b stb=%b we=%b sel=%b stall=%b want all 0",
               o_ce, o_wr_reg_valid, o_misaligned, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_stall);
    end
    tests_run++;
    if (o_rd !== 0 || o_rd_addr !== 0 || o_wb_addr !== 0 || o_wb_data !== 0 || o_opcode !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset data rd=%h rd_addr=%0d addr=%h data=%h opcode=%h want all 0",
               o_rd, o_rd_addr, o_wb_addr, o_wb_data, o_opcode);
    end
    reset = 1'b1;
  endtask

  task automatic test_alu();
    run_alu(32'h1234_5678, 5'd5, 1'b1, "alu");
  endtask

  task automatic test_loads_stores();
    run_mem(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 5'd7, 0, 2, "lb");
    run_mem(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 5'd9, 0, 0, "lhu");
    run_mem(1'b1, 3'b001, 32'h0000_0102, 32'hAAAA_1234, 32'h0, 5'd3, 0, 1, "sh");
    run_mem(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 5'd4, 0, 0, "lw_misaligned");
    run_mem(1'b1, 3'b010, 32'h0000_0240, 32'hCAFE_F00D, 32'h0, 5'd0, 3, 1, "sw_bus_stall");
  endtask

  task automatic test_flush();
    @(negedge clk);
    i_ce = 1'b1; i_flush = 1'b1; i_opcode = op_alu; i_rd = 32'hDEAD_BEEF;
    @(negedge clk);
    i_opcode = op_load; i_funct3 = 3'b010; i_rd = 32'h0000_0300;
    tests_run++; if (o_ce !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_alu o_ce got %b want 0", o_ce); end
    @(negedge clk);
    i_ce = 1'b0; i_flush = 1'b0;
    tests_run++; if (o_ce !== 1'b0 || o_wb_cyc !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_load ce/cyc got %b/%b want 0/0", o_ce, o_wb_cyc); end
  endtask

  task automatic test_wb_hold();
    @(negedge clk);
    i_ce = 1'b1; i_opcode = op_alu; i_rd = 32'h0BAD_F00D; i_rd_addr = 5'd12; i_wr_reg_valid = 1'b1;
    @(negedge clk);
    i_rd = 32'h5555_AAAA; i_rd_addr = 5'd13; i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (o_ce !== 1'b1 || o_rd !== 32'h0BAD_F00D || o_rd_addr !== 5'd12 || o_stall !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL wb_hold ce=%b rd=%h rd_addr=%0d stall=%b want 1/0bad_f00d/12/1",
                 o_ce, o_rd, o_rd_addr, o_stall);
      end
    end
    i_stall = 1'b0; i_ce = 1'b0;
    @(negedge clk);
    tests_run++; if (o_ce !== 1'b0 || o_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL wb_release ce/stall got %b/%b want 0/0", o_ce, o_stall); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_ce = 1'b1; i_opcode = op_load; i_funct3 = 3'b010; i_rd = 32'h0000_0200;
    i_rd_addr = 5'd6; i_wr_reg_valid = 1'b1; i_wb_stall = 1'b0; i_wb_ack = 1'b0;
    @(negedge clk);
    i_ce = 1'b0;
    @(negedge clk);
    tests_run++; if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mid wait cyc/stb got %b/%b want 1/0", o_wb_cyc, o_wb_stb); end
    #1 reset = 1'b0;
    #1;
    tests_run++; if (o_wb_cyc !== 1'b0 || o_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mid async cyc/stall got %b/%b want 0/0", o_wb_cyc, o_stall); end
    @(negedge clk);
    reset = 1'b1; i_wb_ack = 1'b1; i_wb_data = 32'h1111_2222;
    @(negedge clk);
    i_wb_ack = 1'b0;
    tests_run++; if (o_ce !== 1'b0 || o_wb_cyc !== 1'b0 || o_rd !== 32'h0) begin tests_failed++; $display("[TB] FAIL late_ack ce/cyc/rd got %b/%b/%h want 0/0/0", o_ce, o_wb_cyc, o_rd); end
    run_mem(1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'h7654_3210, 5'd8, 0, 1, "lw_after_reset");
  endtask

  task automatic test_random();
    logic [2:0] load_f3 [5];
    load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: run_alu($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "rand_alu");
        1: run_mem(1'b0, load_f3[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                   5'($urandom_range(1, 31)), $urandom_range(0, 2), $urandom_range(0, 2), "rand_load");
        default: run_mem(1'b1, 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                         5'($urandom_range(0, 31)), $urandom_range(0, 2), $urandom_range(0, 2), "rand_store");
      endcase
    end
  endtask

  initial begin
    op_alu   = '0; op_alu[OPC_RTYPE]  = 1'b1;
    op_load  = '0; op_load[OPC_LOAD]  = 1'b1;
    op_store = '0; op_store[OPC_STORE] = 1'b1;
    reset = 1'b0; i_ce = 1'b0; i_opcode = '0; i_funct3 = 3'b0; i_rd = 32'h0; i_rs2 = 32'h0;
    i_rd_addr = 5'h0; i_wr_reg_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 32'h0;
    test_reset();
    test_alu();
    test_loads_stores();
    test_flush();
    test_wb_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
